// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One shift-add (mult) or restoring-subtract (div) step per clock; sign fix-up in a final cycle.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    // Handshake: start/hi_we/lo_we are honoured only at an edge where busy=0;
    // done is a single-cycle pulse in the first idle cycle after the HI/LO write.
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t               state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic                 neg_a_q, neg_a_d;
    logic                 neg_b_q, neg_b_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;

    // op[1] selects divide, op[0] selects unsigned.
    logic                 rs_neg, rt_neg;
    logic [WIDTH-1:0]     rs_mag, rt_mag;
    logic [WIDTH:0]       mult_sum;
    logic [WIDTH:0]       rem_sh;
    logic                 rem_ge;
    logic [WIDTH-1:0]     rem_sub;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix;

    assign rs_neg   = ~op[0] & rs_data[WIDTH-1];
    assign rt_neg   = ~op[0] & rt_data[WIDTH-1];
    assign rs_mag   = rs_neg ? -rs_data : rs_data;
    assign rt_mag   = rt_neg ? -rt_data : rt_data;

    // Mult: upper half accumulates, multiplier shifts out of the low end.
    assign mult_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, b_q} : '0);
    // Div: partial remainder in the upper half, dividend/quotient in the lower half.
    assign rem_sh   = p_q[2*WIDTH-1:WIDTH-1];
    assign rem_ge   = rem_sh >= {1'b0, b_q};
    assign rem_sub  = rem_sh[WIDTH-1:0] - b_q;

    assign prod_fix = (neg_a_q ^ neg_b_q) ? -p_q : p_q;
    assign quo_fix  = (neg_a_q ^ neg_b_q) ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
    assign rem_fix  = neg_a_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        cnt_d   = cnt_q;
        b_d     = b_q;
        p_d     = p_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (start) begin
                    op_d    = op;
                    neg_a_d = rs_neg;
                    neg_b_d = rt_neg;
                    cnt_d   = '0;
                    state_d = S_CALC;
                    if (op[1]) begin
                        b_d = rt_mag;
                        p_d = {{WIDTH{1'b0}}, rs_mag};
                    end else begin
                        b_d = rs_mag;
                        p_d = {{WIDTH{1'b0}}, rt_mag};
                    end
                end
            end
            S_CALC: begin
                if (op_q[1]) begin
                    p_d = {(rem_ge ? rem_sub : rem_sh[WIDTH-1:0]), p_q[WIDTH-2:0], rem_ge};
                end else begin
                    p_d = {mult_sum, p_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = S_FIX;
            end
            S_FIX: begin
                if (op_q[1]) begin
                    // Zero divisor leaves the dividend as remainder; only the quotient needs forcing.
                    lo_d = (b_q == '0) ? '1 : quo_fix;
                    hi_d = rem_fix;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            cnt_q   <= '0;
            b_q     <= '0;
            p_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            cnt_q   <= cnt_d;
            b_q     <= b_d;
            p_q     <= p_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule
